// File: rtl/knap_pkg.sv
// Shared knapsack item tables, widths, state encoding and the per-subset totals record.
package knap_pkg;
  localparam int N_ITEMS = 5;
  localparam int W       = 32;

  // Packed item4..item0, so item i occupies bits [i*W +: W].
  localparam logic [N_ITEMS*W-1:0] ITEM_VALUE  = {32'd10, 32'd1, 32'd2, 32'd2, 32'd4};
  localparam logic [N_ITEMS*W-1:0] ITEM_WEIGHT = {32'd4,  32'd1, 32'd2, 32'd1, 32'd12};
  localparam logic [N_ITEMS*W-1:0] ITEM_VOLUME = {32'd1,  32'd1, 32'd1, 32'd1, 32'd1};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [W-1:0] value;
    logic [W-1:0] weight;
    logic [W-1:0] volume;
  } totals_t;
endpackage

// File: rtl/knap_eval.sv
// Combinational totals and feasibility for one item selection.
module knap_eval
  import knap_pkg::*;
#(
  parameter int                     N_ITEMS     = knap_pkg::N_ITEMS,
  parameter int                     W           = knap_pkg::W,
  parameter logic [N_ITEMS*W-1:0]   ITEM_VALUE  = knap_pkg::ITEM_VALUE,
  parameter logic [N_ITEMS*W-1:0]   ITEM_WEIGHT = knap_pkg::ITEM_WEIGHT,
  parameter logic [N_ITEMS*W-1:0]   ITEM_VOLUME = knap_pkg::ITEM_VOLUME
) (
  input  logic [N_ITEMS-1:0] sel,
  input  logic [W-1:0]       min_value,
  input  logic [W-1:0]       max_weight,
  input  logic [W-1:0]       max_volume,
  output logic [W-1:0]       total_value,
  output logic [W-1:0]       total_weight,
  output logic [W-1:0]       total_volume,
  output logic               feasible
);
  logic [N_ITEMS-1:0][W-1:0] v_item, w_item, u_item;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    assign v_item[i] = sel[i] ? ITEM_VALUE[i*W +: W]  : '0;
    assign w_item[i] = sel[i] ? ITEM_WEIGHT[i*W +: W] : '0;
    assign u_item[i] = sel[i] ? ITEM_VOLUME[i*W +: W] : '0;
  end

  always_comb begin
    total_value  = '0;
    total_weight = '0;
    total_volume = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      total_value  = total_value  + v_item[i];
      total_weight = total_weight + w_item[i];
      total_volume = total_volume + u_item[i];
    end
  end

  assign feasible = (total_value >= min_value) && (total_weight <= max_weight) &&
                    (total_volume <= max_volume);
endmodule

// File: rtl/knap_subset_enum.sv
// Enumerates every item subset, streams feasible ones over valid/ready and tracks best/count.
module knap_subset_enum
  import knap_pkg::*;
#(
  parameter int                   N_ITEMS     = knap_pkg::N_ITEMS,
  parameter int                   W           = knap_pkg::W,
  parameter logic [N_ITEMS*W-1:0] ITEM_VALUE  = knap_pkg::ITEM_VALUE,
  parameter logic [N_ITEMS*W-1:0] ITEM_WEIGHT = knap_pkg::ITEM_WEIGHT,
  parameter logic [N_ITEMS*W-1:0] ITEM_VOLUME = knap_pkg::ITEM_VOLUME
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       min_value,
  input  logic [W-1:0]       max_weight,
  input  logic [W-1:0]       max_volume,
  output logic               busy,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [N_ITEMS-1:0] sol_sel,
  output logic [W-1:0]       sol_value,
  output logic               done,
  output logic [N_ITEMS-1:0] best_sel,
  output logic [W-1:0]       best_value,
  output logic               best_found,
  output logic [N_ITEMS:0]   sol_count
);
  localparam logic [N_ITEMS-1:0] IDX_LAST = '1;

  state_t             state, state_nxt;
  logic [N_ITEMS-1:0] idx;
  logic [W-1:0]       lim_min, lim_wt, lim_vol;
  totals_t            cand;
  logic               cand_ok, adv, take_best;
  logic               unused_totals;

  knap_eval #(
    .N_ITEMS(N_ITEMS), .W(W), .ITEM_VALUE(ITEM_VALUE),
    .ITEM_WEIGHT(ITEM_WEIGHT), .ITEM_VOLUME(ITEM_VOLUME)
  ) u_eval (
    .sel(idx), .min_value(lim_min), .max_weight(lim_wt), .max_volume(lim_vol),
    .total_value(cand.value), .total_weight(cand.weight), .total_volume(cand.volume),
    .feasible(cand_ok)
  );

  // Only the value total leaves this block; weight/volume feed feasibility inside knap_eval.
  assign unused_totals = ^{cand.weight, cand.volume};

  assign busy      = (state != IDLE);
  assign adv       = (state == SCAN) && (!sol_valid || sol_ready);
  assign take_best = cand_ok && (!best_found || cand.value > best_value);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (adv && idx == IDX_LAST) state_nxt = DRAIN;
      DRAIN:   if (!sol_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      lim_min    <= '0;
      lim_wt     <= '0;
      lim_vol    <= '0;
      sol_valid  <= 1'b0;
      sol_sel    <= '0;
      sol_value  <= '0;
      done       <= 1'b0;
      best_sel   <= '0;
      best_value <= '0;
      best_found <= 1'b0;
      sol_count  <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lim_min    <= min_value;
          lim_wt     <= max_weight;
          lim_vol    <= max_volume;
          idx        <= '0;
          best_sel   <= '0;
          best_value <= '0;
          best_found <= 1'b0;
          sol_count  <= '0;
        end
        SCAN: if (adv) begin
          if (idx != IDX_LAST) idx <= idx + 1'b1;
          // adv guarantees the slot is empty or being drained this cycle.
          if (cand_ok) begin
            sol_valid <= 1'b1;
            sol_sel   <= idx;
            sol_value <= cand.value;
            sol_count <= sol_count + 1'b1;
          end else begin
            sol_valid <= 1'b0;
          end
          if (take_best) begin
            best_sel   <= idx;
            best_value <= cand.value;
            best_found <= 1'b1;
          end
        end
        DRAIN: begin
          if (sol_valid && sol_ready) sol_valid <= 1'b0;
          else if (!sol_valid)        done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_knap_subset_enum.sv
// Directed bench for knap_subset_enum using hand-derived solution lists for the default item tables.
module tb_knap_subset_enum;
  import knap_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, sol_ready;
  logic [31:0] min_value, max_weight, max_volume;
  logic        busy, sol_valid, done, best_found;
  logic [4:0]  sol_sel, best_sel;
  logic [31:0] sol_value, best_value;
  logic [5:0]  sol_count;

  knap_subset_enum dut (
    .clk(clk), .rst(rst), .start(start), .min_value(min_value), .max_weight(max_weight),
    .max_volume(max_volume), .busy(busy), .sol_valid(sol_valid), .sol_ready(sol_ready),
    .sol_sel(sol_sel), .sol_value(sol_value), .done(done), .best_sel(best_sel),
    .best_value(best_value), .best_found(best_found), .sol_count(sol_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand values per item A..E
  function automatic logic [31:0] hval(input logic [4:0] s);
    int unsigned v[5] = '{4, 2, 2, 1, 10};
    hval = 0;
    for (int i = 0; i < 5; i++) if (s[i]) hval += v[i];
  endfunction

  // Consumer: picks ready, logs handshakes, checks data holds while stalled.
  logic [4:0]  got_sel[$];
  logic [31:0] got_val[$];
  int          done_cnt = 0;
  bit          rand_rdy = 0, stall = 0;
  logic [4:0]  st_sel;
  logic [31:0] st_val;

  always @(negedge clk) begin
    if (stall) begin
      chk("stall_valid", sol_valid, 1);
      chk("stall_sel", sol_sel, st_sel);
      chk("stall_value", sol_value, st_val);
    end
    sol_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (done) done_cnt++;
    if (sol_valid && sol_ready) begin
      got_sel.push_back(sol_sel);
      got_val.push_back(sol_value);
    end
    stall  = sol_valid && !sol_ready && !rst;
    st_sel = sol_sel;
    st_val = sol_value;
  end

  task automatic run_scan(input logic [31:0] mn, input logic [31:0] wt, input logic [31:0] vol,
                          input bit disturb, output int cyc);
    got_sel.delete();
    got_val.delete();
    done_cnt = 0;
    @(negedge clk);
    min_value = mn; max_weight = wt; max_volume = vol; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk); cyc++;
      #1;
      if (disturb && cyc == 5) begin
        start = 1'b1; min_value = 0; max_weight = 100; max_volume = 100;
      end
      if (disturb && cyc == 6) start = 1'b0;
      if (done) break;
    end
    chk("done_seen", done, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_after", busy, 0);
  endtask

  task automatic chk_list(input string tag, input int exp_sel[], input int n);
    chk({tag, "_n"}, got_sel.size(), n);
    for (int i = 0; i < n && i < got_sel.size(); i++) begin
      chk({tag, "_sel"}, got_sel[i], exp_sel[i]);
      chk({tag, "_val"}, got_val[i], hval(5'(exp_sel[i])));
    end
  endtask

  int all25[] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17,
                  18, 20, 22, 24, 26, 28, 30};
  int one1e[] = '{30};

  task automatic chk_one1e(input string tag, input int cyc);
    chk_list(tag, one1e, 1);
    chk({tag, "_cnt"}, sol_count, 1);
    chk({tag, "_bsel"}, best_sel, 5'h1E);
    chk({tag, "_bval"}, best_value, 15);
    chk({tag, "_bfound"}, best_found, 1);
    chk({tag, "_cyc"}, cyc, 33);
  endtask

  initial begin
    longint sv = 0, sw = 0, su = 0;
    for (int i = 0; i < N_ITEMS; i++) begin
      sv += ITEM_VALUE[i*W +: W];
      sw += ITEM_WEIGHT[i*W +: W];
      su += ITEM_VOLUME[i*W +: W];
    end
    assert (sv < 64'h1_0000_0000 && sw < 64'h1_0000_0000 && su < 64'h1_0000_0000)
      else $error("item table sums overflow W bits");
  end

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; min_value = 0; max_weight = 0; max_volume = 0; sol_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", sol_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sol_sel, 0);
    chk("rst_sval", sol_value, 0);
    chk("rst_bsel", best_sel, 0);
    chk("rst_bval", best_value, 0);
    chk("rst_bfound", best_found, 0);
    chk("rst_cnt", sol_count, 0);
    @(negedge clk) rst = 1'b0;

    run_scan(15, 16, 10, 0, cyc);
    chk_one1e("t1", cyc);

    run_scan(0, 16, 10, 0, cyc);
    chk_list("t2", all25, 25);
    chk("t2_cnt", sol_count, 25);
    chk("t2_bsel", best_sel, 5'h1E);
    chk("t2_bval", best_value, 15);
    chk("t2_cyc", cyc, 33);

    rand_rdy = 1;
    run_scan(0, 16, 10, 0, cyc);
    rand_rdy = 0;
    chk_list("t3", all25, 25);
    chk("t3_cnt", sol_count, 25);
    chk("t3_bsel", best_sel, 5'h1E);
    chk("t3_late", cyc > 33, 1);

    run_scan(20, 16, 10, 0, cyc);
    chk("t4_n", got_sel.size(), 0);
    chk("t4_cnt", sol_count, 0);
    chk("t4_bfound", best_found, 0);
    chk("t4_cyc", cyc, 33);

    // Abort while idx == 10 is being presented.
    done_cnt = 0;
    @(negedge clk);
    min_value = 0; max_weight = 16; max_volume = 10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", sol_valid, 0);
    chk("t5_cnt", sol_count, 0);
    chk("t5_bfound", best_found, 0);
    chk("t5_sel", sol_sel, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    run_scan(15, 16, 10, 0, cyc);
    chk_one1e("t5r", cyc);

    run_scan(15, 16, 10, 1, cyc);
    chk_one1e("t6", cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
